// File: rtl/imem_req_arbiter_pkg.sv
// imem_req_arbiter_pkg: shared types and constants for the I-cache request arbiter.
package imem_req_arbiter_pkg;
    localparam int ABITS = 64;
    localparam int LOG2_DEPTH = 2;
    typedef logic req_id_t;
    typedef struct packed {
        req_id_t id;
        logic    disc;
    } fifo_entry_t;
    typedef struct packed {
        logic    req_valid;
        req_id_t req_id;
        logic    req_disc;
        req_id_t last_grant;
        logic    proto_err;
    } imem_arb_registers;
    localparam imem_arb_registers imem_arb_r_reset = '{
        req_valid: 1'b0, req_id: 1'b0, req_disc: 1'b0, last_grant: 1'b1, proto_err: 1'b0
    };
endpackage

// File: rtl/imem_req_arbiter_if.sv
// imem_req_arbiter_if: requester, I-cache and response buses of the arbiter.
interface imem_req_arbiter_if #(parameter int abits = imem_req_arbiter_pkg::ABITS);
    logic [1:0]       req_valid;
    logic [abits-1:0] req_addr0;
    logic [abits-1:0] req_addr1;
    logic [1:0]       req_ready;
    logic             mem_req_valid;
    logic [abits-1:0] mem_req_addr;
    logic             mem_req_ready;
    logic             mem_resp_valid;
    logic [abits-1:0] mem_resp_addr;
    logic [63:0]      mem_resp_data;
    logic             mem_load_fault;
    logic             mem_page_fault_x;
    logic             mem_resp_ready;
    logic [1:0]       resp_valid;
    logic [abits-1:0] resp_addr;
    logic [63:0]      resp_data;
    logic             resp_load_fault;
    logic             resp_page_fault_x;
    logic [1:0]       resp_ready;
    logic             flush;
    logic             proto_err;
    modport slave (
        input  req_valid, req_addr0, req_addr1, mem_req_ready, mem_resp_valid, mem_resp_addr,
               mem_resp_data, mem_load_fault, mem_page_fault_x, resp_ready, flush,
        output req_ready, mem_req_valid, mem_req_addr, mem_resp_ready, resp_valid, resp_addr,
               resp_data, resp_load_fault, resp_page_fault_x, proto_err
    );
    modport master (
        output req_valid, req_addr0, req_addr1, mem_req_ready, mem_resp_valid, mem_resp_addr,
               mem_resp_data, mem_load_fault, mem_page_fault_x, resp_ready, flush,
        input  req_ready, mem_req_valid, mem_req_addr, mem_resp_ready, resp_valid, resp_addr,
               resp_data, resp_load_fault, resp_page_fault_x, proto_err
    );
endinterface

// File: rtl/imem_req_arbiter_tagfifo.sv
// imem_req_arbiter_tagfifo: in-order {requester id, discard} tags of accepted requests.
module imem_req_arbiter_tagfifo
    import imem_req_arbiter_pkg::*;
#(
    parameter int log2_depth = LOG2_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  fifo_entry_t         push_entry,
    input  logic                pop,
    input  logic                flush_mark,
    output fifo_entry_t         head,
    output logic [log2_depth:0] count
);
    localparam int DEPTH = 2 ** log2_depth;
    fifo_entry_t mem [DEPTH];
    logic [log2_depth-1:0] wptr, rptr;
    assign head = mem[rptr];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // the pushed entry already carries its own discard, so it overrides the mark
            if (flush_mark) for (int i = 0; i < DEPTH; i++) mem[i].disc <= 1'b1;
            if (push) mem[wptr] <= push_entry;
            if (push) wptr <= wptr + log2_depth'(1);
            if (pop) rptr <= rptr + log2_depth'(1);
            count <= count + (log2_depth + 1)'(push) - (log2_depth + 1)'(pop);
        end
endmodule

// File: rtl/imem_req_arbiter.sv
// imem_req_arbiter: round-robin sharing of the I-cache port between fetch and prefetch,
// with in-order response routing and flush-discard of in-flight responses.
module imem_req_arbiter
    import imem_req_arbiter_pkg::*;
#(
    parameter int abits = ABITS,
    parameter int log2_depth = LOG2_DEPTH
) (
    input logic clk,
    input logic rst,
    imem_req_arbiter_if.slave bus
);
    localparam int DEPTH = 2 ** log2_depth;
    imem_arb_registers r, rin, v;
    logic [abits-1:0] addr, addr_in;
    logic [log2_depth:0] count;
    fifo_entry_t head, push_entry;
    logic accept, grant_ok, g, pop, empty, mem_resp_ready;
    logic [1:0] req_ready, resp_valid;

    imem_req_arbiter_tagfifo #(.log2_depth(log2_depth)) tagfifo (
        .clk(clk), .rst(rst), .push(accept), .push_entry(push_entry), .pop(pop),
        .flush_mark(bus.flush), .head(head), .count(count)
    );

    always_comb begin : comb_proc
        v = r;
        addr_in = addr;
        accept = r.req_valid && bus.mem_req_ready;
        // the entry accepted this cycle occupies a FIFO slot from the next edge on
        grant_ok = (!r.req_valid || accept) && (int'(count) + int'(accept) < DEPTH) && !bus.flush && !rst;
        g = (&bus.req_valid) ? !r.last_grant : bus.req_valid[1];
        req_ready = (grant_ok && |bus.req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
        push_entry = '{id: r.req_id, disc: r.req_disc || bus.flush};
        if (accept) v.req_valid = 1'b0;
        if (bus.flush && r.req_valid) v.req_disc = 1'b1;
        if (|req_ready) begin
            v.req_valid = 1'b1;
            v.req_id = g;
            v.req_disc = 1'b0;
            v.last_grant = g;
            addr_in = g ? bus.req_addr1 : bus.req_addr0;
        end
        empty = count == '0;
        resp_valid = (bus.mem_resp_valid && !empty && !head.disc) ? (head.id ? 2'b10 : 2'b01) : 2'b00;
        mem_resp_ready = bus.mem_resp_valid && (empty || head.disc || bus.resp_ready[head.id]);
        pop = mem_resp_ready && !empty;
        if (bus.mem_resp_valid && empty) v.proto_err = 1'b1;
        rin = v;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r <= imem_arb_r_reset;
            addr <= '1;
        end else begin
            r <= rin;
            addr <= addr_in;
        end

    assign bus.req_ready = req_ready;
    assign bus.mem_req_valid = r.req_valid;
    assign bus.mem_req_addr = addr;
    assign bus.mem_resp_ready = mem_resp_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_addr = bus.mem_resp_addr;
    assign bus.resp_data = bus.mem_resp_data;
    assign bus.resp_load_fault = bus.mem_load_fault;
    assign bus.resp_page_fault_x = bus.mem_page_fault_x;
    assign bus.proto_err = r.proto_err;
endmodule

// File: tb/tb_imem_req_arbiter.sv
// tb_imem_req_arbiter: directed checks of grant order, stall, FIFO limit, flush discard,
// protocol error and reset.
module tb_imem_req_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    imem_req_arbiter_if bus ();
    imem_req_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.req_addr0 = '0;
        bus.req_addr1 = '0;
        bus.mem_req_ready = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_addr = 64'h1000;
        bus.mem_resp_data = 64'hDEAD_BEEF_0000_0013;
        bus.mem_load_fault = 1'b0;
        bus.mem_page_fault_x = 1'b1;
        bus.resp_ready = 2'b00;
        bus.flush = 1'b0;
        #12;
        chk("rst_mem_req_valid", bus.mem_req_valid, 0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_mem_resp_ready", bus.mem_resp_ready, 0);
        chk("rst_proto_err", bus.proto_err, 0);
        @(negedge clk);
        rst = 1'b0;
        // T1: single fetch request
        bus.req_valid = 2'b01;
        bus.req_addr0 = 64'h1000;
        bus.req_addr1 = 64'h8000;
        #1 chk("t1_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        #1 chk("t1_mem_valid", bus.mem_req_valid, 1);
        chk("t1_mem_addr", bus.mem_req_addr, 64'h1000);
        tick();
        chk("t1_slot_empty", bus.mem_req_valid, 0);
        bus.mem_resp_valid = 1'b1;
        #1 chk("t1_resp_valid", bus.resp_valid, 2'b01);
        chk("t1_backpressure", bus.mem_resp_ready, 0);
        bus.resp_ready = 2'b01;
        #1 chk("t1_resp_ready", bus.mem_resp_ready, 1);
        chk("t1_resp_data", bus.resp_data, 64'hDEAD_BEEF_0000_0013);
        chk("t1_resp_pfx", bus.resp_page_fault_x, 1);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.resp_ready = 2'b11;
        // T2/T4: both requesting; last grant was fetch, so prefetch goes first
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2_grant", bus.req_ready, (i % 2) ? 2'b01 : 2'b10);
            if (i > 0) chk("t2_addr", bus.mem_req_addr, (i % 2) ? 64'h8000 : 64'h1000);
            tick();
        end
        chk("t4_full_block", bus.req_ready, 0);
        chk("t4_last_addr", bus.mem_req_addr, 64'h1000);
        bus.req_valid = 2'b01;
        tick();
        chk("t4_still_block", bus.req_ready, 0);
        chk("t4_slot_idle", bus.mem_req_valid, 0);
        bus.mem_resp_valid = 1'b1;
        #1 chk("t4_resp0_id", bus.resp_valid, 2'b10);
        chk("t4_pop_full_block", bus.req_ready, 0);
        tick();
        chk("t4_resp1_id", bus.resp_valid, 2'b01);
        chk("t4_unblock", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        #1 chk("t4_resp2_id", bus.resp_valid, 2'b10);
        tick();
        chk("t4_resp3_id", bus.resp_valid, 2'b01);
        tick();
        chk("t4_resp4_id", bus.resp_valid, 2'b01);
        tick();
        bus.mem_resp_valid = 1'b0;
        // T3: I-cache stall holds the slot
        bus.mem_req_ready = 1'b0;
        bus.req_valid = 2'b01;
        bus.req_addr0 = 64'h2000;
        #1 chk("t3_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b10;
        bus.req_addr1 = 64'h3000;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3_hold_addr", bus.mem_req_addr, 64'h2000);
            chk("t3_no_grant", bus.req_ready, 0);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        #1 chk("t3_reload_grant", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = 2'b00;
        #1 chk("t3_new_addr", bus.mem_req_addr, 64'h3000);
        tick();
        bus.mem_resp_valid = 1'b1;
        #1 chk("t3_resp0_id", bus.resp_valid, 2'b01);
        tick();
        chk("t3_resp1_id", bus.resp_valid, 2'b10);
        tick();
        bus.mem_resp_valid = 1'b0;
        // T5: flush with two in flight
        bus.req_valid = 2'b01;
        bus.req_addr0 = 64'h4000;
        tick();
        bus.req_valid = 2'b10;
        bus.req_addr1 = 64'h5000;
        tick();
        bus.req_valid = 2'b01;
        bus.flush = 1'b1;
        #1 chk("t5_flush_no_grant", bus.req_ready, 0);
        tick();
        bus.flush = 1'b0;
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b00;
        bus.mem_resp_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("t5_disc_resp_valid", bus.resp_valid, 0);
            chk("t5_disc_consumed", bus.mem_resp_ready, 1);
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        bus.req_valid = 2'b01;
        bus.req_addr0 = 64'h6000;
        #1 chk("t5_new_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.resp_ready = 2'b01;
        #1 chk("t5_new_routed", bus.resp_valid, 2'b01);
        chk("t5_new_ready", bus.mem_resp_ready, 1);
        tick();
        // T6: response with nothing outstanding
        chk("t6_err_before", bus.proto_err, 0);
        chk("t6_orphan_ready", bus.mem_resp_ready, 1);
        chk("t6_orphan_no_route", bus.resp_valid, 0);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1 chk("t6_err_set", bus.proto_err, 1);
        tick();
        chk("t6_err_sticky", bus.proto_err, 1);
        bus.mem_req_ready = 1'b0;
        bus.req_valid = 2'b01;
        bus.req_addr0 = 64'h7000;
        tick();
        bus.req_valid = 2'b00;
        #1 chk("t6_pending", bus.mem_req_valid, 1);
        rst = 1'b1;
        #1 chk("t6_rst_mem_valid", bus.mem_req_valid, 0);
        chk("t6_rst_addr", bus.mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_rst_err", bus.proto_err, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 2'b11;
        #1 chk("t6_rst_tie_fetch", bus.req_ready, 2'b01);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
